// File: rtl/enc8to3_arb.sv
// enc8to3_arb -- 8-to-3 request encoder/arbiter with a one-deep output register.
//
// Requests are captured into a pending vector. Whenever the output register
// is free (empty, or being accepted this cycle) and en=1, one pending index
// is selected, loaded into code and cleared from pending. A request arriving
// for an index that is already pending is merged into it and counted.
//
// Configuration macro:
//   ENC_RR_PRIORITY_EN  defined   -> round-robin selection (downward search
//                                    starting just below the last loaded index)
//                       undefined -> fixed priority, bit 7 highest
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   request strobes, one request per high cycle per bit
//   en         load enable for the output register
//   ready      consumer accepts code when valid is high
//   code[2:0]  granted index (registered)
//   valid      code holds a granted, not yet accepted index (registered)
//   pending    captured, not yet granted requests (registered)
//   idle       pending==0 and valid==0 (combinational)
//   merge_cnt  saturating count of requests merged into a pending bit
module enc8to3_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       en,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       idle,
  output logic [7:0] merge_cnt
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  function automatic logic [2:0] prio_sel(input logic [7:0] p);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) if (p[i]) s = 3'(i);
    return s;
  endfunction

`ifdef ENC_RR_PRIORITY_EN
  // Search last-1, last-2, ... wrapping through 0->7; last itself is checked
  // last, so a lone request at the previously granted index is still served.
  function automatic logic [2:0] rr_sel(input logic [7:0] p, input logic [2:0] last_idx);
    logic [2:0] s;
    logic [2:0] idx;
    logic       found;
    s     = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_idx - 3'(k);
      if (!found && p[idx]) begin
        s     = idx;
        found = 1'b1;
      end
    end
    return s;
  endfunction

  logic [2:0] last;
`endif

  logic [2:0] sel;
  logic       load;
  logic [7:0] load_mask;
  logic [7:0] merge_bits;
  logic [7:0] pending_next;

  always_comb begin
`ifdef ENC_RR_PRIORITY_EN
    sel = rr_sel(pending, last);
`else
    sel = prio_sel(pending);
`endif
    // Output register is free when empty or when its code is accepted now.
    load         = en && (pending != 8'h00) && (!valid || ready);
    load_mask    = load ? (8'h01 << sel) : 8'h00;
    // A request for the index being loaded this edge re-arms that bit and is
    // a fresh request, not a merge.
    merge_bits   = req & pending & ~load_mask;
    pending_next = (pending & ~load_mask) | req;
  end

  assign idle = (pending == 8'h00) && !valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code      <= 3'd0;
      valid     <= 1'b0;
      pending   <= 8'h00;
      merge_cnt <= 8'h00;
`ifdef ENC_RR_PRIORITY_EN
      last      <= 3'd0;
`endif
    end else begin
      pending   <= pending_next;
      merge_cnt <= sat_add8(merge_cnt, popcount8(merge_bits));
      if (load) begin
        code  <= sel;
        valid <= 1'b1;
`ifdef ENC_RR_PRIORITY_EN
        last  <= sel;
`endif
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc8to3_arb.sv
// tb_enc8to3_arb -- directed bench for enc8to3_arb.
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge (or asynchronously while reset is asserted).
module tb_enc8to3_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       en;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       idle;
  logic [7:0] merge_cnt;

  int vectors    = 0;
  int miscompares = 0;

  enc8to3_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .ready     (ready),
    .code      (code),
    .valid     (valid),
    .pending   (pending),
    .idle      (idle),
    .merge_cnt (merge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] c, input logic v, input logic [7:0] p);
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
    if (v) chk({tag, ".code"}, {5'd0, code}, {5'd0, c});
    chk({tag, ".pending"}, pending, p);
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 8'h00;
    en    = 1'b1;
    ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.code",    {5'd0, code}, 8'h00);
    chk("rst.valid",   {7'd0, valid}, 8'h00);
    chk("rst.pending", pending, 8'h00);
    chk("rst.idle",    {7'd0, idle}, 8'h01);
    chk("rst.merge",   merge_cnt, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet after reset.
    for (int i = 0; i < 4; i++) cyc(8'h00);
    chk("quiet.valid",   {7'd0, valid}, 8'h00);
    chk("quiet.idle",    {7'd0, idle}, 8'h01);
    chk("quiet.pending", pending, 8'h00);
    chk("quiet.merge",   merge_cnt, 8'h00);

    // 8'h24: capture, then 5 and 2 back to back, then empty.
    cyc(8'h24); chk_out("p24.e1", 3'd0, 1'b0, 8'h24);
    cyc(8'h00); chk_out("p24.e2", 3'd5, 1'b1, 8'h04);
    cyc(8'h00); chk_out("p24.e3", 3'd2, 1'b1, 8'h00);
    cyc(8'h00); chk_out("p24.e4", 3'd0, 1'b0, 8'h00);
    chk("p24.idle", {7'd0, idle}, 8'h01);

    // Hold code 3 with ready=0 while 7 arrives; 7 follows once accepted.
    ready = 1'b0;
    cyc(8'h08); chk_out("hold.cap", 3'd0, 1'b0, 8'h08);
    cyc(8'h00); chk_out("hold.load", 3'd3, 1'b1, 8'h00);
    cyc(8'h80); chk_out("hold.c1", 3'd3, 1'b1, 8'h80);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00);
      chk("hold.code", {5'd0, code}, 8'h03);
      chk("hold.valid", {7'd0, valid}, 8'h01);
    end
    ready = 1'b1;
    cyc(8'h00); chk_out("hold.next7", 3'd7, 1'b1, 8'h00);
    cyc(8'h00); chk_out("hold.drain", 3'd0, 1'b0, 8'h00);

    // Merges with the output blocked.
    en = 1'b0;
    cyc(8'h01); chk_out("merge.cap", 3'd0, 1'b0, 8'h01);
    chk("merge.cnt0", merge_cnt, 8'h00);
    cyc(8'h01);
    chk("merge.cnt1", merge_cnt, 8'h01);
    chk("merge.noload", {7'd0, valid}, 8'h00);
    for (int i = 0; i < 299; i++) begin
      cyc(8'h01);
      if (i == 252) chk("merge.cnt254", merge_cnt, 8'hFE);
    end
    chk("merge.sat", merge_cnt, 8'hFF);
    // Load of index 0 together with a new req for 0 keeps bit 0 pending.
    en = 1'b1;
    cyc(8'h01); chk_out("merge.reload", 3'd0, 1'b1, 8'h01);
    cyc(8'h00); chk_out("merge.b2b0", 3'd0, 1'b1, 8'h00);
    cyc(8'h00); chk_out("merge.empty", 3'd0, 1'b0, 8'h00);
    chk("merge.hold", merge_cnt, 8'hFF);

    // Asynchronous reset during HOLD with pending F0.
    ready = 1'b0;
    cyc(8'h08); chk_out("arst.cap", 3'd0, 1'b0, 8'h08);
    cyc(8'hF0); chk_out("arst.hold", 3'd3, 1'b1, 8'hF0);
    req = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.code",    {5'd0, code}, 8'h00);
    chk("arst.valid",   {7'd0, valid}, 8'h00);
    chk("arst.pending", pending, 8'h00);
    chk("arst.idle",    {7'd0, idle}, 8'h01);
    chk("arst.merge",   merge_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    cyc(8'h00); chk_out("arst.after", 3'd0, 1'b0, 8'h00);

`ifdef ENC_RR_PRIORITY_EN
    cyc(8'hFF); chk_out("rr.cap", 3'd0, 1'b0, 8'hFF);
    for (int i = 7; i >= 0; i--) begin
      cyc(8'h00);
      chk("rr.code", {5'd0, code}, 8'(i));
      chk("rr.valid", {7'd0, valid}, 8'h01);
    end
    cyc(8'h00); chk_out("rr.empty", 3'd0, 1'b0, 8'h00);
    cyc(8'h81); chk_out("rr81.cap", 3'd0, 1'b0, 8'h81);
    cyc(8'h00); chk_out("rr81.c7", 3'd7, 1'b1, 8'h01);
    cyc(8'h00); chk_out("rr81.c0", 3'd0, 1'b1, 8'h00);
    cyc(8'h00); chk_out("rr81.empty", 3'd0, 1'b0, 8'h00);
`else
    cyc(8'h81); chk_out("fp81.cap", 3'd0, 1'b0, 8'h81);
    cyc(8'h00); chk_out("fp81.c7", 3'd7, 1'b1, 8'h01);
    cyc(8'h00); chk_out("fp81.c0", 3'd0, 1'b1, 8'h00);
    cyc(8'h00); chk_out("fp81.empty", 3'd0, 1'b0, 8'h00);
    cyc(8'hFF); chk_out("fpFF.cap", 3'd0, 1'b0, 8'hFF);
    cyc(8'h00); chk_out("fpFF.c7", 3'd7, 1'b1, 8'h7F);
    cyc(8'h80); chk_out("fpFF.c6", 3'd6, 1'b1, 8'hBF);
    cyc(8'h00); chk_out("fpFF.c7b", 3'd7, 1'b1, 8'h3F);
    cyc(8'h00); chk_out("fpFF.c5", 3'd5, 1'b1, 8'h1F);
    cyc(8'h00); chk_out("fpFF.c4", 3'd4, 1'b1, 8'h0F);
    cyc(8'h00); chk_out("fpFF.c3", 3'd3, 1'b1, 8'h07);
    cyc(8'h00); chk_out("fpFF.c2", 3'd2, 1'b1, 8'h03);
    cyc(8'h00); chk_out("fpFF.c1", 3'd1, 1'b1, 8'h01);
    cyc(8'h00); chk_out("fpFF.c0", 3'd0, 1'b1, 8'h00);
    cyc(8'h00); chk_out("fpFF.empty", 3'd0, 1'b0, 8'h00);
`endif
    chk("end.idle", {7'd0, idle}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc8to3_arb.md
ENC8TO3_ARB -- requirements
Module: enc8to3_arb

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req  input  8  request strobes; bit i high for one clk means one request for index i.
REQ-004 en  input  1  load enable; 0 blocks new codes from loading into the output register.
REQ-005 ready  input  1  consumer accepts code when high with valid.
REQ-006 code  output  3  encoded index of the granted request; registered.
REQ-007 valid  output  1  code holds a granted, unaccepted index; registered.
REQ-008 pending  output  8  registered vector of captured, not-yet-granted requests.
REQ-009 idle  output  1  combinational; high when pending==0 and valid==0.
REQ-010 merge_cnt  output  8  saturating count of merged (lost-duplicate) requests.

Function
REQ-011 The block has two states: EMPTY (valid=0) and HOLD (valid=1).
REQ-012 "Load" occurs at an edge when en=1, pending!=0, and (state EMPTY, or state HOLD with ready=1).
REQ-013 On load, the block enters or stays in HOLD, code takes the selected index, and the selected bit clears from pending.
REQ-014 Selection: fixed priority, highest index wins (bit 7 highest); selection uses the pending register only, never same-cycle req.
REQ-015 Each edge: pending_next = (pending & ~load_mask) | req, where load_mask is the one-hot of the loaded index or 0 if no load.
REQ-016 If req bit i and a load of index i occur at the same edge, bit i remains set in pending_next.
REQ-017 Latency: a req pulse sampled at edge k appears in pending after edge k; with the output free and en=1, valid and code appear after edge k+1.
REQ-018 In HOLD with ready=0, code and valid hold stable.
REQ-019 In HOLD with ready=1 and no load, valid clears after the edge and the block returns to EMPTY.
REQ-020 Back-to-back: in HOLD with ready=1 and a load, valid stays 1 and code updates at the same edge, with no bubble.
REQ-021 With en=0, req is still captured into pending; an accepted code still clears valid; no load occurs.
REQ-022 Merge: when req bit i=1 while pending bit i=1 and no load of i at that edge, merge_cnt increments by the number of such bits, saturating at 255.
REQ-023 A request whose index currently sits in code (HOLD) is not a merge; it sets pending bit i.

Reset
REQ-024 When rst_n=0, the block asynchronously forces code=0, valid=0, pending=0, merge_cnt=0, and the round-robin pointer=0; idle reads 1.
REQ-025 Reset assertion mid-HOLD discards the held code and all pending requests; the first edge after deassertion behaves as from EMPTY.

Configuration
REQ-026 With macro ENC_RR_PRIORITY_EN defined, selection is round-robin: a 3-bit pointer last holds the most recently loaded index.
REQ-027 Under ENC_RR_PRIORITY_EN, the search runs downward from (last-1) mod 8 and wraps 0->7; last updates on every load.
REQ-028 Under ENC_RR_PRIORITY_EN, the reset value of last is 0, so the first search starts at index 7 and the first grant matches fixed priority.
REQ-029 Without ENC_RR_PRIORITY_EN, the pointer is absent and REQ-014 fixed priority applies.

Verification
REQ-030 The bench shall cover: reset, then req=8'h00 for 4 cycles -> valid=0, idle=1, pending=0, merge_cnt=0.
REQ-031 The bench shall cover: req=8'h24 for 1 cycle, ready=1 -> codes 5 then 2 on consecutive cycles with valid high for exactly 2 cycles, pending=0 afterward.
REQ-032 The bench shall cover: code=3 held with ready=0 for 5 cycles while req=8'h80 is pulsed -> code stays 3; after ready=1, next code=7.
REQ-033 The bench shall cover: req=8'h01 pulsed twice while bit 0 is pending and the output is blocked (en=0) -> merge_cnt=1; 300 such merges -> merge_cnt=255.
REQ-034 The bench shall cover: rst_n low during HOLD with pending=8'hF0 -> code=0, valid=0, and pending=0 immediately, before the next clk edge.
REQ-035 The bench shall cover (ENC_RR_PRIORITY_EN): req=8'hFF once, ready=1 -> code sequence 7,6,5,4,3,2,1,0; then req=8'h81 -> code 7 then 0; without the macro, req=8'h81 -> code 7 then 0 as well, and req=8'hFF followed by req=8'h80 during the draining -> 7 reappears before lower indices.
